// File: rtl/ifu_axi_rd_if.sv
// AXI4-style read channel bundle (AR + R) between an instruction-fetch
// master and a read responder.
//
// Handshake rule for both channels: a transfer happens in a cycle where
// valid & ready are both 1 on the rising clock edge. Once valid is raised,
// the source keeps it and its payload steady until that transfer happens.
// Ready may depend on the sink's state but never on valid in the same cycle.
//
// Signals:
//   AR: arvalid, arready, araddr[31:0], arid, arlen[7:0], arsize[2:0], arburst[1:0]
//   R : rvalid, rready, rdata[31:0], rid, rresp[1:0], rlast
interface ifu_axi_rd_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rid;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/ifu_axi_rd_responder.sv
// Single-outstanding AXI read responder backed by a word memory.
// Accepts one AR burst at a time, waits RD_LATENCY cycles, then streams
// arlen+1 beats (FIXED / INCR / WRAP) with OKAY, SLVERR or DECERR.
// A backdoor write port preloads the memory at any time, including reset.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   bus            ifu_axi_rd_if.slave (AR and R channels)
//   init_we        backdoor write enable
//   init_addr      backdoor byte address (same map as araddr)
//   init_data      backdoor write data
//   dbg_state      current FSM state (0 IDLE, 1 WAIT, 2 BURST)
module ifu_axi_rd_responder #(
  parameter int          MEM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          RD_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  ifu_axi_rd_if.slave         bus,
  input  logic                init_we,
  input  logic [31:0]         init_addr,
  input  logic [31:0]         init_data,
  output logic [1:0]          dbg_state
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t      state, state_next;

  logic [31:0] mem [MEM_WORDS];

  // Captured burst attributes; addr_q holds the address of the beat on the bus.
  logic [31:0] addr_q;
  logic        id_q;
  logic [7:0]  len_q;
  logic [1:0]  burst_q;
  logic        err_q;
  logic [7:0]  beat_cnt;
  logic [3:0]  wait_cnt, wait_next;

  logic        rvalid_q, rlast_q, rid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        arready_c, capture, load, finish, ar_err;
  logic [31:0] next_addr, wrap_mask, incr_addr;
  logic [31:0] ld_addr, ld_off;
  logic [7:0]  ld_cnt, ld_len;
  logic        ld_err, ld_id, ld_in_range;
  logic [31:0] ld_data;
  logic [1:0]  ld_resp;

  logic [31:0] init_off;
  logic        init_in_range;

  assign dbg_state = state;

  // A bad size, reserved burst type or illegal wrap length poisons every beat.
  always_comb begin
    ar_err = (bus.arsize != 3'b010) || (bus.arburst == 2'b11);
    if (bus.arburst == BURST_WRAP &&
        !(bus.arlen == 8'd1 || bus.arlen == 8'd3 ||
          bus.arlen == 8'd7 || bus.arlen == 8'd15))
      ar_err = 1'b1;
  end

  // WRAP keeps the bits above the (len+1)*4-byte block and wraps the rest.
  always_comb begin
    incr_addr = addr_q + 32'd4;
    wrap_mask = {22'd0, len_q, 2'b11};
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  always_comb begin
    arready_c  = (state == S_IDLE) && !reset;
    state_next = state;
    wait_next  = wait_cnt;
    capture    = 1'b0;
    load       = 1'b0;
    finish     = 1'b0;
    ld_addr    = next_addr;
    ld_cnt     = beat_cnt + 8'd1;
    ld_len     = len_q;
    ld_err     = err_q;
    ld_id      = id_q;
    case (state)
      S_IDLE: begin
        if (bus.arvalid && arready_c) begin
          capture = 1'b1;
          if (RD_LATENCY <= 1) begin
            // Zero wait cycles: load beat 0 straight from the AR payload.
            load       = 1'b1;
            ld_addr    = bus.araddr;
            ld_cnt     = 8'd0;
            ld_len     = bus.arlen;
            ld_err     = ar_err;
            ld_id      = bus.arid;
            state_next = S_BURST;
          end else begin
            wait_next  = 4'd1;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'(RD_LATENCY - 1)) begin
          load       = 1'b1;
          ld_addr    = addr_q;
          ld_cnt     = 8'd0;
          state_next = S_BURST;
        end else begin
          wait_next = wait_cnt + 4'd1;
        end
      end
      S_BURST: begin
        if (bus.rready) begin
          if (rlast_q) begin
            finish     = 1'b1;
            state_next = S_IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Beat payload for the address about to be loaded.
  always_comb begin
    ld_off      = (ld_addr - BASE_ADDR) >> 2;
    ld_in_range = (ld_addr >= BASE_ADDR) && (ld_off < 32'(MEM_WORDS));
    ld_data     = '0;
    ld_resp     = RESP_OKAY;
    if (ld_err)
      ld_resp = RESP_SLVERR;
    else if (!ld_in_range)
      ld_resp = RESP_DECERR;
    else
      ld_data = mem[ld_off[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
      addr_q   <= '0;
      id_q     <= 1'b0;
      len_q    <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rid_q    <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (capture) begin
        addr_q  <= bus.araddr;
        id_q    <= bus.arid;
        len_q   <= bus.arlen;
        burst_q <= bus.arburst;
        err_q   <= ar_err;
      end
      if (load) begin
        addr_q   <= ld_addr;
        beat_cnt <= ld_cnt;
        rvalid_q <= 1'b1;
        rlast_q  <= (ld_cnt == ld_len);
        rid_q    <= ld_id;
        rdata_q  <= ld_data;
        rresp_q  <= ld_resp;
      end else if (finish) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
        beat_cnt <= '0;
      end
    end
  end

  // Backdoor preload: not reset, active in every state; out-of-range dropped.
  always_comb begin
    init_off      = (init_addr - BASE_ADDR) >> 2;
    init_in_range = (init_addr >= BASE_ADDR) && (init_off < 32'(MEM_WORDS));
  end

  always_ff @(posedge clock) begin
    if (init_we && init_in_range)
      mem[init_off[AW-1:0]] <= init_data;
  end

  assign bus.arready = arready_c;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rid     = rid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;

endmodule

// File: tb/tb_ifu_axi_rd_responder.sv
module tb_ifu_axi_rd_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          WORDS = 1024;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUTs (latency 1 and latency 4) ----------------
  ifu_axi_rd_if bus1();
  ifu_axi_rd_if bus4();

  logic        sel = 1'b0;
  logic        arvalid = 1'b0;
  logic [31:0] araddr = '0;
  logic        arid = 1'b0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 2'b01;
  logic        rready = 1'b0;
  logic        init_we = 1'b0;
  logic [31:0] init_addr = '0;
  logic [31:0] init_data = '0;
  logic [1:0]  dbg1, dbg4;

  assign bus1.arvalid = arvalid && !sel;
  assign bus4.arvalid = arvalid && sel;
  assign bus1.araddr = araddr;  assign bus4.araddr = araddr;
  assign bus1.arid = arid;      assign bus4.arid = arid;
  assign bus1.arlen = arlen;    assign bus4.arlen = arlen;
  assign bus1.arsize = arsize;  assign bus4.arsize = arsize;
  assign bus1.arburst = arburst; assign bus4.arburst = arburst;
  assign bus1.rready = rready;  assign bus4.rready = rready;

  logic        o_arready, o_rvalid, o_rid, o_rlast;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp;
  assign o_arready = sel ? bus4.arready : bus1.arready;
  assign o_rvalid  = sel ? bus4.rvalid  : bus1.rvalid;
  assign o_rdata   = sel ? bus4.rdata   : bus1.rdata;
  assign o_rid     = sel ? bus4.rid     : bus1.rid;
  assign o_rresp   = sel ? bus4.rresp   : bus1.rresp;
  assign o_rlast   = sel ? bus4.rlast   : bus1.rlast;

  ifu_axi_rd_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .RD_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data), .dbg_state(dbg1)
  );
  ifu_axi_rd_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .RD_LATENCY(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4.slave),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data), .dbg_state(dbg4)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] model_mem [WORDS];
  logic [35:0] exp_q[$];   // {rid, rlast, rresp, rdata}
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected beats from the burst rules, computed per beat index.
  task automatic model_burst(input logic [31:0] addr, input logic id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic        bad;
    logic [31:0] a, lo, blk, woff;
    bad = (size != 3'd2) || (burst == 2'b11) ||
          (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    blk = (32'(len) + 1) * 4;
    for (int i = 0; i <= int'(len); i++) begin
      case (burst)
        2'b00:   a = addr;
        2'b10: begin
          lo = addr - (addr % blk);
          a  = lo + ((addr - lo + 32'(i) * 4) % blk);
        end
        default: a = addr + 32'(i) * 4;
      endcase
      woff = (a - BASE) / 4;
      if (bad)
        exp_q.push_back({id, (i == int'(len)), 2'b10, 32'd0});
      else if (a < BASE || woff >= WORDS)
        exp_q.push_back({id, (i == int'(len)), 2'b11, 32'd0});
      else
        exp_q.push_back({id, (i == int'(len)), 2'b00, model_mem[woff]});
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at the drive point: 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bd_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] woff;
    init_we = 1'b1; init_addr = addr; init_data = data;
    woff = (addr - BASE) / 4;
    if (addr >= BASE && woff < WORDS) model_mem[woff] = data;
    tick();
    init_we = 1'b0;
  endtask

  task automatic ar_handshake(input logic [31:0] addr, input logic id, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              output int t_hs, output bit ok);
    ok = 0; t_hs = 0;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
    for (int g = 0; g < 20 && !ok; g++) begin
      @(negedge clock);
      if (o_arready) begin ok = 1; t_hs = cyc; end
      tick();
    end
    arvalid = 1'b0;
    if (!ok) check("ar_handshake_timeout", 0, 1);
  endtask

  function automatic logic pick_rready(input int mode, input int k);
    logic [4:0] pat;
    pat = 5'b11001;   // per-beat-cycle pattern 1,0,0,1,1 (bit k)
    case (mode)
      0: return 1'b1;
      1: return ($urandom_range(0, 3) != 0);
      default: return (k < 5) ? pat[k] : 1'b1;
    endcase
  endfunction

  task automatic run_burst(input logic s, input logic [31:0] addr, input logic id,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode);
    int t_hs, n, k, lat;
    bit ok, first, stalled;
    logic [35:0] obs, stall_val, e;
    sel = s;
    lat = s ? 4 : 1;
    model_burst(addr, id, len, size, burst);
    ar_handshake(addr, id, len, size, burst, t_hs, ok);
    if (!ok) begin exp_q.delete(); return; end
    n = 0; k = 0; first = 0; stalled = 0; stall_val = '0;
    for (int g = 0; g < 400 && n <= int'(len); g++) begin
      rready = pick_rready(mode, k);
      @(negedge clock);
      if (o_rvalid) begin
        if (!first) begin
          first = 1;
          check("first_rvalid_latency", 64'(cyc - t_hs), 64'(lat));
        end
        obs = {o_rid, o_rlast, o_rresp, o_rdata};
        if (stalled) check("stall_stable", obs, stall_val);
        if (rready) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          check($sformatf("beat%0d", n), obs, e);
          n++;
          stalled = 0;
        end else begin
          stalled = 1;
          stall_val = obs;
        end
        k++;
      end else if (first) begin
        check("rvalid_dropped_mid_burst", 0, 1);
      end
      tick();
    end
    rready = 1'b0;
    if (n <= int'(len)) check("burst_timeout_beats", 64'(n), 64'(len) + 1);
    exp_q.delete();
    @(negedge clock);
    check("post_burst_rvalid", 64'(o_rvalid), 0);
    check("post_burst_arready", 64'(o_arready), 1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_hs;
    bit ok;
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int r;

    // Preload everything while reset is held; backdoor must work in reset.
    #1;
    for (int i = 0; i < WORDS; i++) bd_write(BASE + 32'(i) * 4, $urandom);
    bd_write(BASE + 0,  32'd11);
    bd_write(BASE + 4,  32'd22);
    bd_write(BASE + 8,  32'd33);
    bd_write(BASE + 12, 32'd44);
    bd_write(BASE + 32'hFFC, 32'hCAFE_0FFC);
    bd_write(BASE + 32'h1000, 32'hDEAD_BEEF);   // out of range: dropped
    bd_write(BASE - 4, 32'hDEAD_BEEF);          // below window: dropped

    @(negedge clock);
    check("reset_arready", 64'(o_arready), 0);
    check("reset_rvalid",  64'(o_rvalid), 0);
    check("reset_rlast",   64'(o_rlast), 0);
    check("reset_rresp",   64'(o_rresp), 0);
    check("reset_rdata",   64'(o_rdata), 0);
    check("reset_rid",     64'(o_rid), 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("arready_after_reset", 64'(o_arready), 1);
    tick();

    // Directed bursts on the latency-1 responder.
    run_burst(0, BASE + 4, 1'b1, 8'd2, 3'd2, 2'b01, 0);     // 22,33,44
    run_burst(0, BASE + 4, 1'b0, 8'd2, 3'd2, 2'b01, 2);     // stalls 1,0,0,1,1
    run_burst(0, BASE + 8, 1'b1, 8'd3, 3'd2, 2'b10, 0);     // wrap 2,3,0,1
    run_burst(0, BASE + 32'hFFC, 1'b0, 8'd1, 3'd2, 2'b01, 0); // off the end
    run_burst(0, BASE, 1'b1, 8'd1, 3'd1, 2'b01, 0);         // bad size
    run_burst(0, BASE, 1'b0, 8'd2, 3'd2, 2'b10, 0);         // bad wrap len
    run_burst(0, BASE + 8, 1'b1, 8'd3, 3'd2, 2'b00, 2);     // fixed
    run_burst(0, BASE, 1'b0, 8'd0, 3'd2, 2'b11, 0);         // reserved burst
    run_burst(0, BASE - 8, 1'b1, 8'd3, 3'd2, 2'b01, 0);     // crosses into window
    run_burst(1, BASE + 4, 1'b1, 8'd2, 3'd2, 2'b01, 2);     // latency 4

    // Reset mid-burst on the latency-4 responder.
    sel = 1'b1;
    ar_handshake(BASE, 1'b1, 8'd7, 3'd2, 2'b01, t_hs, ok);
    rready = 1'b1;
    if (ok) begin
      for (int c = 1; c < 4; c++) begin
        @(negedge clock);
        check("lat4_wait_rvalid", 64'(o_rvalid), 0);
        tick();
      end
      @(negedge clock);
      check("lat4_first_beat", {o_rvalid, o_rid, o_rlast, o_rresp, o_rdata},
            {1'b1, 1'b1, 1'b0, 2'b00, 32'd11});
      tick();
      reset = 1'b1;
      @(negedge clock);
      check("lat4_second_beat", {o_rvalid, o_rdata}, {1'b1, 32'd22});
      tick();
      @(negedge clock);
      check("abort_rvalid", 64'(o_rvalid), 0);
      check("abort_arready_in_reset", 64'(o_arready), 0);
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("abort_arready_after", 64'(o_arready), 1);
      tick();
      for (int c = 0; c < 6; c++) begin
        @(negedge clock);
        check("no_resumed_beats", 64'(o_rvalid), 0);
        tick();
      end
    end
    rready = 1'b0;
    run_burst(1, BASE, 1'b0, 8'd3, 3'd2, 2'b01, 0);         // memory preserved
    run_burst(0, BASE, 1'b1, 8'd3, 3'd2, 2'b01, 1);

    // Randomized bursts with interleaved backdoor writes.
    for (int it = 0; it < 60; it++) begin
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        r = $urandom_range(0, 5);
        if (r == 0) bd_write(BASE + 32'h1000 + 32'($urandom_range(0, 63)) * 4, $urandom);
        else bd_write(BASE + 32'($urandom_range(0, WORDS - 1)) * 4, $urandom);
      end
      r = $urandom_range(0, 9);
      burst = (r < 3) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if (burst == 2'b10 && $urandom_range(0, 5) != 0) begin
        r = $urandom_range(0, 3);
        len = (r == 0) ? 8'd1 : (r == 1) ? 8'd3 : (r == 2) ? 8'd7 : 8'd15;
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      r = $urandom_range(0, 9);
      if (r == 0) a = BASE - 32'($urandom_range(1, 4)) * 4;
      else if (r == 1) a = BASE + 32'($urandom_range(WORDS - 8, WORDS - 1)) * 4;
      else a = BASE + 32'($urandom_range(0, WORDS - 1)) * 4;
      if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
      run_burst(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), len, size, burst, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #2000000;
    check("global_timeout", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
